synchronous_fifo_msb: RTL and testbench



---
 rtl/synchronous_fifo_msb_pkg.sv | 7 +
 rtl/synchronous_fifo_msb_fifo_ptr.sv | 34 +++
 rtl/synchronous_fifo_msb.sv | 72 +++++++
 tb/tb_synchronous_fifo_msb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/synchronous_fifo_msb_pkg.sv
// Shared defaults for the MSB-parity synchronous FIFO.
package synchronous_fifo_msb_pkg;

    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/synchronous_fifo_msb_fifo_ptr.sv
// Wrapping binary pointer with increment enable; the extra MSB carries wrap parity.
module fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Natural overflow of the full-width counter toggles the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/synchronous_fifo_msb.sv
// Single-clock FIFO using (AW+1)-bit pointers for full/empty detection and a registered read port.
module synchronous_fifo_msb
    import synchronous_fifo_msb_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wr_fire = w_en && !full;
    assign rd_fire = r_en && !empty;

    fifo_ptr #(.PTR_W(AW + 1)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_fire),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.PTR_W(AW + 1)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_fire),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (rd_fire) begin
            data_out_d = mem_q[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_synchronous_fifo_msb.sv
// Randomised self-checking bench for synchronous_fifo_msb against a queue-based model.
module tb_synchronous_fifo_msb;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq [$];
    logic [DW-1:0] exp_dout;

    synchronous_fifo_msb #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one clock edge and advance the model: pop then push, each gated on pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        bit do_rd;
        bit do_wr;
        w_en    = w;
        r_en    = r;
        data_in = d;
        do_rd   = r && (mq.size() > 0);
        do_wr   = w && (mq.size() < DEPTH);
        @(posedge clk);
        if (do_rd) exp_dout = mq.pop_front();
        if (do_wr) mq.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        w_en = 1'b0; r_en = 1'b0; data_in = '0;
        @(posedge clk); #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: empty=%b full=%b data_out=%h, need empty=1 full=0 data_out=00", empty, full, data_out);
        end
        rst_n = 1'b1;
        mq.delete();
        exp_dout = '0;
        step(1'b0, 1'b0, '0);
        checks++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: empty=%b data_out=%h, need 1/00", empty, data_out);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, words[i]);
            checks++;
            if (full !== (i == 7) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_flags[%0d]: full=%b empty=%b, need full=%b empty=0", i, full, empty, (i == 7));
            end
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] words [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== words[i] || empty !== (i == 7) || full !== 1'b0) begin
                errors++;
                $display("FAIL drain[%0d]: data_out=%h empty=%b full=%b, need %h empty=%b full=0",
                         i, data_out, empty, full, words[i], (i == 7));
            end
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (data_out !== 8'h12 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold: data_out=%h empty=%b, need 12 empty=1", data_out, empty);
        end
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, d[i]);
            checks++;
            // First edge sees an empty FIFO, so data_out keeps the last drained word.
            if (data_out !== ((i == 0) ? 8'h12 : d[i-1]) || empty !== 1'b0 || full !== 1'b0) begin
                errors++;
                $display("FAIL concurrent[%0d]: data_out=%h empty=%b full=%b, need %h empty=0 full=0",
                         i, data_out, empty, full, (i == 0) ? 8'h12 : d[i-1]);
            end
        end
        checks++;
        if (mq.size() != 1) begin
            errors++;
            $display("FAIL concurrent_occupancy: model=%0d, need 1", mq.size());
        end
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== d[3] || empty !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_last: data_out=%h empty=%b, need %h empty=1", data_out, empty, d[3]);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 8'hA9)));
        step(1'b1, 1'b0, 8'hAA);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0 || mq.size() != DEPTH) begin
            errors++;
            $display("FAIL overflow_flags: full=%b empty=%b, need full=1 empty=0", full, empty);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== exp_dout || data_out === 8'hAA || empty !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: data_out=%h empty=%b, need %h empty=%b",
                         i, data_out, empty, exp_dout, (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_underflow_wrap();
        logic [DW-1:0] held;
        int written;
        int cyc;
        held = data_out;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, DW'($urandom));
            checks++;
            if (data_out !== held || empty !== 1'b1 || full !== 1'b0) begin
                errors++;
                $display("FAIL underflow[%0d]: data_out=%h empty=%b, need %h empty=1", i, data_out, empty, held);
            end
        end
        written = 0;
        cyc = 0;
        while ((written < 20 || mq.size() > 0) && cyc < 200) begin
            logic w;
            logic r;
            w = (written < 20) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0) || (written >= 20);
            if (w && mq.size() < DEPTH) written++;
            step(w, r, DW'($urandom));
            cyc++;
            checks++;
            if (data_out !== exp_dout || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL wrap[%0d]: data_out=%h empty=%b full=%b, need %h empty=%b full=%b",
                         cyc, data_out, empty, full, exp_dout, (mq.size() == 0), (mq.size() == DEPTH));
            end
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL wrap_budget: cycles=%0d, need under 200", cyc);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
        w_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: empty=%b full=%b data_out=%h, need 1/0/00", empty, full, data_out);
        end
        mq.delete();
        exp_dout = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read: data_out=%h empty=%b, need 00 empty=1", data_out, empty);
        end
        step(1'b1, 1'b0, 8'h5C);
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 8'h5C || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_data: data_out=%h empty=%b, need 5c empty=1", data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_overflow();
        test_underflow_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
